uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (8N1); legal range 2..65535.
- REQ-002: Parameter FIFO_DEPTH, default 4, byte entries in the transmit queue; power of two, minimum 2.
- REQ-003: Port CLK  input  1  single clock; all state updates on the rising edge.
- REQ-004: Port RST_N  input  1  reset, asynchronous, active-low.
- REQ-005: Port wr_arg  input  9  write request from the core's UART write method; bit 8 = valid, bits 7:0 = data byte.
- REQ-006: Port wr_ready  output  1  write-accept indication returned to the core.
- REQ-007: Port tx  output  1  serial line; idle high.
- REQ-008: Port busy  output  1  high while any byte is queued or being shifted.

Function
- REQ-009: A byte SHALL be accepted on a rising edge where wr_arg[8]=1 and wr_ready=1; no other condition accepts a byte.
- REQ-010: wr_ready SHALL be 1 exactly when the FIFO holds fewer than FIFO_DEPTH entries, decoded from registered state only, with no combinational path from wr_arg.
- REQ-011: wr_arg[7:0] SHALL be ignored whenever wr_arg[8]=0.
- REQ-012: The FIFO SHALL be first-in first-out, with an occupancy count of width clog2(FIFO_DEPTH)+1.
- REQ-013: Read and write pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-014: A push and a pop on the same edge SHALL leave occupancy unchanged.
- REQ-015: The FSM SHALL have the states IDLE, START, DATA and STOP.
- REQ-016: In IDLE with FIFO non-empty (registered), the FSM SHALL pop one byte into the shift register and enter START on that edge.
- REQ-017: In IDLE with the FIFO empty, the FSM SHALL remain in IDLE and perform no pop.
- REQ-018: tx SHALL be registered; tx=0 in START, tx=current data bit in DATA (LSB first), and tx=1 in STOP and IDLE.
- REQ-019: START, each of the 8 DATA bits, and STOP SHALL each last exactly CLKS_PER_BIT cycles.
- REQ-020: The bit-time counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every bit boundary, and have width clog2(CLKS_PER_BIT).
- REQ-021: Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
- REQ-022: First-byte latency: for a byte accepted on edge t into an empty, idle block, tx SHALL first be 0 after edge t+2.
- REQ-023: On the last STOP cycle with the FIFO non-empty, the FSM SHALL pop the next byte and go directly to START, with no idle gap between frames.
- REQ-024: On the last STOP cycle with the FIFO empty, the FSM SHALL go to IDLE.
- REQ-025: DATA SHALL track the bit index 0..7 and exit to STOP after bit 7 completes.
- REQ-026: busy SHALL equal (state != IDLE) OR (occupancy != 0).
- REQ-027: No accepted byte SHALL be dropped, duplicated or reordered under any push/pop interleaving.

Reset
- REQ-028: RST_N=0 SHALL immediately (asynchronously) force state=IDLE, bit counter=0, bit index=0, FIFO pointers and occupancy=0.
- REQ-029: While RST_N=0, outputs SHALL be tx=1, wr_ready=1 and busy=0.
- REQ-030: Reset asserted mid-frame SHALL abort the frame, drive tx=1 without waiting for a clock, and discard all queued bytes.
- REQ-031: FIFO storage contents SHALL NOT require reset.
- REQ-032: After RST_N deasserts, the first rising edge SHALL be able to accept a byte.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
- REQ-033: Single byte 0x55 accepted at edge t -> tx=1 until t+2, then 40 cycles of 0,1,0,1,0,1,0,1,0,1 (4 cycles each), then tx=1, busy=0, state IDLE.
- REQ-034: valid held high continuously with bytes 0x01,0x02,... -> exactly 5 bytes accepted before wr_ready first drops; frames 0x01..0x05 emitted back-to-back, with no tx=1 cycle between a stop bit and the next start bit.
- REQ-035: wr_arg=9'h0AA (valid=0) for 50 cycles -> no acceptance, tx=1, busy=0 throughout.
- REQ-036: RST_N pulled low during DATA bit 3 of 0x00 with 3 bytes queued -> tx=1 and busy=0 before the next edge; after release, wr_ready=1 and no stale bytes are transmitted.
- REQ-037: FIFO full, with the final STOP cycle pop coinciding with a core write attempt -> that write is refused on that edge (wr_ready=0) and accepted on the next edge; occupancy never exceeds 4.
- REQ-038: Random valid/data stimulus, 1000 bytes -> a UART receiver model recovers the identical byte sequence.

Source files
------------

// File: rtl/uart_tx_if.sv
// Write-side handshake between the core's UART write method and uart_tx.
// The core presents {valid, data} on wr_arg. The transmitter returns wr_ready.
`timescale 1ns/1ps

interface uart_tx_if;
  logic [8:0] wr_arg;
  logic       wr_ready;

  modport master (output wr_arg, input  wr_ready);
  modport slave  (input  wr_arg, output wr_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Bytes are popped straight from the FIFO into the shift register. Frames
// run back-to-back while the FIFO holds data. tx is registered from the FSM
// state, so the serial line trails the state machine by one clock.
`timescale 1ns/1ps

module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  uart_tx_if.slave  wr,
  output logic      tx,
  output logic      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;

  logic push, pop, bit_done, fifo_nonempty;

  // Ready depends only on registered occupancy, so there is no path from wr_arg.
  assign wr.wr_ready   = (occ_reg != OCC_W'(FIFO_DEPTH));
  assign push          = wr.wr_arg[8] & wr.wr_ready;
  assign fifo_nonempty = (occ_reg != '0);
  assign bit_done      = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign tx            = tx_reg;
  assign busy          = (state_reg != ST_IDLE) || fifo_nonempty;

  // Storage is not reset; the reset pointers make stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wr.wr_arg[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Frame sequencing: the bit timer and the bit index drive the state changes,
  // and a pop is made on entry to START from IDLE or from the end of STOP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == 3'd7) begin
            idx_next   = '0;
            state_next = ST_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (fifo_nonempty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // FSM registers. Reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Serial line register. Reset forces the line idle without waiting for a clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_START: tx_reg <= 1'b0;
        ST_DATA:  tx_reg <= shift_reg[0];
        default:  tx_reg <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Accepted bytes go into a scoreboard queue. A receiver process decodes tx
// and pops the queue, and the directed steps check exact line timing.
`timescale 1ns/1ps

module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic tx, busy;

  uart_tx_if wr_bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .wr    (wr_bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 CLK = ~CLK;

  int         tests = 0;
  int         fails = 0;
  int         rx_count = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_byte;
  bit         rx_abort;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected line level k samples after the accepting edge, for nframes
  // consecutive bytes first, first+1, ... sent back-to-back.
  function automatic logic exp_tx(int k, logic [7:0] first, int nframes);
    int m, f, j;
    logic [7:0] b;
    if (k < 2) return 1'b1;
    m = k - 2;
    f = m / FRAME;
    if (f >= nframes) return 1'b1;
    j = (m % FRAME) / CPB;
    b = first + 8'(f);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Receiver model: samples the middle of each bit and pops the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && tx === 1'b0) begin
        rx_abort = 1'b0;
        rx_byte  = '0;
        for (int s = 1; s <= 38 && !rx_abort; s++) begin
          @(negedge CLK);
          if (RST_N !== 1'b1) begin
            rx_abort = 1'b1;
          end else if (s == 2) begin
            check("rx_start_bit", tx, 0);
          end else if (s >= 6 && s <= 34 && ((s - 6) % 4) == 0) begin
            rx_byte[(s - 6) / 4] = tx;
          end
        end
        if (!rx_abort) begin
          check("rx_stop_bit", tx, 1);
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL rx_unexpected_byte: observed %0h expected none", rx_byte);
          end
          if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
          rx_count++;
        end
      end
    end
  end

  initial begin
    int acc, cyc, base;
    logic [7:0] next_b;
    logic [7:0] rst_bytes [4];
    bit seen_drop;
    bit v;
    logic [7:0] d;

    wr_bus.wr_arg = '0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx", tx, 1);
    check("reset_wr_ready", wr_bus.wr_ready, 1);
    check("reset_busy", busy, 0);

    // Single byte 0x55, offered on the very first edge after reset release.
    RST_N = 1'b1;
    wr_bus.wr_arg = {1'b1, 8'h55};
    exp_q.push_back(8'h55);
    for (int k = 0; k <= 45; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        wr_bus.wr_arg = '0;
        check("single_busy_after_accept", busy, 1);
      end
      check("single_tx", tx, exp_tx(k, 8'h55, 1));
    end
    check("single_busy_end", busy, 0);
    check("single_rx_count", rx_count, 1);

    // Valid low with data present: nothing accepted, line stays idle.
    wr_bus.wr_arg = 9'h0AA;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      check("invalid_ignored", {tx, busy, wr_bus.wr_ready}, 3'b101);
    end
    wr_bus.wr_arg = '0;
    repeat (45) @(negedge CLK);
    check("invalid_rx_count", rx_count, 1);

    // Valid held high: fill the FIFO, then keep offering byte 6 until the
    // STOP-cycle pop frees a slot. Frames must run back-to-back.
    acc = 0;
    next_b = 8'h01;
    seen_drop = 1'b0;
    for (int k = -1; k <= 250; k++) begin
      if (k >= 0) begin
        @(negedge CLK);
        check("b2b_tx", tx, exp_tx(k, 8'h01, 6));
      end
      if (k <= 41) check("b2b_wr_ready", wr_bus.wr_ready, (k >= 4 && k <= 40) ? 0 : 1);
      if (!wr_bus.wr_ready && !seen_drop) begin
        seen_drop = 1'b1;
        check("b2b_accepted_before_full", acc, 5);
      end
      if (acc < 6) begin
        wr_bus.wr_arg = {1'b1, next_b};
        if (wr_bus.wr_ready) begin
          exp_q.push_back(next_b);
          acc++;
          next_b++;
        end
      end else begin
        wr_bus.wr_arg = '0;
      end
    end
    check("b2b_busy_end", busy, 0);
    check("b2b_rx_count", rx_count, 7);

    // Reset during DATA bit 3 of 0x00 with three bytes queued behind it.
    rst_bytes[0] = 8'h00; rst_bytes[1] = 8'h11; rst_bytes[2] = 8'h22; rst_bytes[3] = 8'h33;
    acc = 0;
    for (int k = -1; k <= 19; k++) begin
      if (k >= 0) @(negedge CLK);
      if (k == 18) check("rst_mid_frame_tx", tx, 0);
      if (k == 19) begin
        RST_N = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_wr_ready", wr_bus.wr_ready, 1);
        exp_q.delete();
      end else if (acc < 4) begin
        wr_bus.wr_arg = {1'b1, rst_bytes[acc]};
        if (wr_bus.wr_ready) begin
          exp_q.push_back(rst_bytes[acc]);
          acc++;
        end
      end else begin
        wr_bus.wr_arg = '0;
      end
    end
    wr_bus.wr_arg = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    base = rx_count;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      check("post_rst_idle", {tx, busy, wr_bus.wr_ready}, 3'b101);
    end
    check("post_rst_no_stale", rx_count, base);

    // Random valid/data until 1000 bytes are accepted.
    acc = 0;
    cyc = 0;
    base = rx_count;
    while (acc < 1000 && cyc < 60000) begin
      @(negedge CLK);
      cyc++;
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      wr_bus.wr_arg = {v, d};
      if (v && wr_bus.wr_ready) begin
        exp_q.push_back(d);
        acc++;
      end
    end
    @(negedge CLK);
    wr_bus.wr_arg = '0;
    check("random_accepted", acc, 1000);
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    repeat (10) @(negedge CLK);
    check("random_queue_drained", exp_q.size(), 0);
    check("random_busy_end", busy, 0);
    check("random_rx_count", rx_count - base, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
